// File: rtl/zapper_port_ctrl.sv
// rtl/zapper_port_ctrl.sv - NES $4016/$4017 pad and zapper port scheduler
//
// Serialises the two pad button bytes through per-port shift registers and
// routes the zapper light/trigger lines onto D3/D4 of one port. A routing
// change waits for vblank, then the newly routed port reports "no light,
// no trigger" for SETTLE_FRAMES further vblanks.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   ce                CPU clock enable qualifying strobe_we and rd
//   strobe, strobe_we $4016 write data bit D0 and write pulse
//   rd[1:0]           read pulses: rd[0] = $4016, rd[1] = $4017
//   joy0, joy1        pad buttons, bit0=A .. bit7=Right, active high
//   zap_sel           requested zapper routing (00 none, 01 port 1, 10 port 2)
//   zap_light         zapper light sense, 0 = light seen
//   zap_trigger       zapper trigger, active high
//   vblank_start      one-clk pulse at start of vblank
//   dout0, dout1      port read data D4..D0
//   zap_active        routing currently applied
module zapper_port_ctrl #(
    parameter int SETTLE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       strobe,
    input  logic       strobe_we,
    input  logic [1:0] rd,
    input  logic [7:0] joy0,
    input  logic [7:0] joy1,
    input  logic [1:0] zap_sel,
    input  logic       zap_light,
    input  logic       zap_trigger,
    input  logic       vblank_start,
    output logic [4:0] dout0,
    output logic [4:0] dout1,
    output logic [1:0] zap_active
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SETTLE  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_FRAMES);

    state_t     state_q, state_d;
    logic       strobe_reg_q, strobe_reg_d;
    logic [7:0] sr0_q, sr0_d;
    logic [7:0] sr1_q, sr1_d;
    logic       trig_latch_q, trig_latch_d;
    logic [1:0] zap_active_q, zap_active_d;
    logic [3:0] settle_cnt_q, settle_cnt_d;

    logic [1:0] req_sel;
    logic       strobe_eff;
    logic       zap_rd;
    logic       settling;
    logic       zap_d3;
    logic       zap_d4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            strobe_reg_q <= 1'b0;
            sr0_q        <= 8'hFF;
            sr1_q        <= 8'hFF;
            trig_latch_q <= 1'b0;
            zap_active_q <= 2'b00;
            settle_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            strobe_reg_q <= strobe_reg_d;
            sr0_q        <= sr0_d;
            sr1_q        <= sr1_d;
            trig_latch_q <= trig_latch_d;
            zap_active_q <= zap_active_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    always_comb begin
        req_sel      = (zap_sel == 2'b11) ? 2'b00 : zap_sel;
        // A strobe written this cycle already decides reload versus shift.
        strobe_eff   = (ce && strobe_we) ? strobe : strobe_reg_q;
        strobe_reg_d = strobe_eff;
        settling     = (state_q == ST_SETTLE);

        sr0_d = sr0_q;
        sr1_d = sr1_q;
        if (ce && strobe_eff) begin
            sr0_d = joy0;
            sr1_d = joy1;
        end else if (ce) begin
            if (rd[0]) sr0_d = {1'b1, sr0_q[7:1]};
            if (rd[1]) sr1_d = {1'b1, sr1_q[7:1]};
        end

        zap_rd = ce && (((zap_active_q == 2'b01) && rd[0]) ||
                        ((zap_active_q == 2'b10) && rd[1]));

        // Trigger latch: a live trigger wins over a clearing read, so a held
        // trigger keeps reporting until it is released and read once more.
        trig_latch_d = trig_latch_q;
        if ((zap_active_q == 2'b00) || settling) begin
            trig_latch_d = 1'b0;
        end else if (zap_trigger) begin
            trig_latch_d = 1'b1;
        end else if (zap_rd) begin
            trig_latch_d = 1'b0;
        end

        state_d      = state_q;
        zap_active_d = zap_active_q;
        settle_cnt_d = settle_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_sel != zap_active_q) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                if (req_sel == zap_active_q) begin
                    state_d = ST_IDLE;
                end else if (vblank_start) begin
                    zap_active_d = req_sel;
                    settle_cnt_d = SETTLE_INIT;
                    if ((SETTLE_FRAMES == 0) || (req_sel == 2'b00)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (vblank_start) begin
                    if (settle_cnt_q <= 4'd1) begin
                        settle_cnt_d = 4'd0;
                        state_d      = ST_IDLE;
                    end else begin
                        settle_cnt_d = settle_cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // While settling the routed port looks like a gun aimed at the dark.
        zap_d3 = settling ? 1'b1 : zap_light;
        zap_d4 = settling ? 1'b0 : (zap_trigger | trig_latch_q);

        if (zap_active_q == 2'b01) begin
            dout0 = {zap_d4, zap_d3, 3'b000};
        end else begin
            dout0 = {4'b0000, strobe_reg_q ? joy0[0] : sr0_q[0]};
        end
        if (zap_active_q == 2'b10) begin
            dout1 = {zap_d4, zap_d3, 3'b000};
        end else begin
            dout1 = {4'b0000, strobe_reg_q ? joy1[0] : sr1_q[0]};
        end
        zap_active = zap_active_q;
    end

endmodule

// File: tb/tb_zapper_port_ctrl.sv
// tb/tb_zapper_port_ctrl.sv - self-checking bench for zapper_port_ctrl
module tb_zapper_port_ctrl;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b1;
    logic       strobe = 1'b0;
    logic       strobe_we = 1'b0;
    logic [1:0] rd = 2'b00;
    logic [7:0] joy0 = 8'h00;
    logic [7:0] joy1 = 8'h00;
    logic [1:0] zap_sel = 2'b00;
    logic       zap_light = 1'b1;
    logic       zap_trigger = 1'b0;
    logic       vblank_start = 1'b0;
    logic [4:0] dout0, dout1;
    logic [1:0] zap_active;

    zapper_port_ctrl #(.SETTLE_FRAMES(SETTLE)) dut (
        .clk(clk), .reset(reset), .ce(ce), .strobe(strobe),
        .strobe_we(strobe_we), .rd(rd), .joy0(joy0), .joy1(joy1),
        .zap_sel(zap_sel), .zap_light(zap_light), .zap_trigger(zap_trigger),
        .vblank_start(vblank_start), .dout0(dout0), .dout1(dout1),
        .zap_active(zap_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pad bits still to be read, as queues (empty = all 1s).
    bit         model_valid = 0;
    bit         strobe_m = 0;
    bit         q0[$];
    bit         q1[$];
    bit         latch_m = 0;
    logic [1:0] act_m = 2'b00;
    bit         pending_m = 0;
    int         settle_left = 0;

    logic [4:0] obs0, obs1;
    logic [1:0] obs_act;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] exp_port(input int n);
        logic [7:0] joy;
        bit         head;
        joy = (n == 0) ? joy0 : joy1;
        if (int'(act_m) == n + 1) begin
            if (settle_left > 0) return 5'b01000;
            return {zap_trigger | latch_m, zap_light, 3'b000};
        end
        if (n == 0) head = (q0.size() > 0) ? q0[0] : 1'b1;
        else        head = (q1.size() > 0) ? q1[0] : 1'b1;
        return {4'b0000, strobe_m ? joy[0] : head};
    endfunction

    task automatic tick();
        logic [1:0] req;
        bit         eff;
        int         zp;
        @(negedge clk);
        obs0 = dout0;
        obs1 = dout1;
        obs_act = zap_active;
        if (model_valid) begin
            chk("model_dout0", {3'b0, obs0}, {3'b0, exp_port(0)});
            chk("model_dout1", {3'b0, obs1}, {3'b0, exp_port(1)});
            chk("model_zap_active", {6'b0, obs_act}, {6'b0, act_m});
        end
        @(posedge clk);
        if (reset) begin
            model_valid = 1;
            strobe_m = 0;
            q0 = {};
            q1 = {};
            latch_m = 0;
            act_m = 2'b00;
            pending_m = 0;
            settle_left = 0;
        end else begin
            req = (zap_sel == 2'b11) ? 2'b00 : zap_sel;
            eff = (ce && strobe_we) ? strobe : strobe_m;
            zp = int'(act_m) - 1;
            if (act_m == 2'b00 || settle_left > 0) latch_m = 0;
            else if (zap_trigger) latch_m = 1;
            else if (ce && rd[zp]) latch_m = 0;
            if (ce && eff) begin
                q0 = {};
                q1 = {};
                for (int i = 0; i < 8; i++) begin
                    q0.push_back(joy0[i]);
                    q1.push_back(joy1[i]);
                end
            end else if (ce) begin
                if (rd[0] && q0.size() > 0) void'(q0.pop_front());
                if (rd[1] && q1.size() > 0) void'(q1.pop_front());
            end
            strobe_m = eff;
            if (settle_left > 0) begin
                if (vblank_start) settle_left--;
            end else if (pending_m) begin
                if (req == act_m) begin
                    pending_m = 0;
                end else if (vblank_start) begin
                    act_m = req;
                    settle_left = (req != 2'b00) ? SETTLE : 0;
                    pending_m = 0;
                end
            end else begin
                pending_m = (req != act_m);
            end
        end
        #1;
    endtask

    logic [9:0] exp_seq;

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_dout0", {3'b0, obs0}, 8'h01);
        chk("reset_dout1", {3'b0, obs1}, 8'h01);
        chk("reset_zap_active", {6'b0, obs_act}, 8'h00);

        // Pad stream A5 read ten times, then ones
        joy0 = 8'hA5;
        strobe_we = 1'b1; strobe = 1'b1; tick();
        strobe = 1'b0; tick();
        strobe_we = 1'b0;
        exp_seq = 10'b1110100101;
        rd = 2'b01;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("pad_seq_%0d", i), {7'b0, obs0[0]}, {7'b0, exp_seq[i]});
        end
        rd = 2'b00;

        // Strobe held high: D0 follows joy0[0] live
        strobe_we = 1'b1; strobe = 1'b1; tick();
        strobe_we = 1'b0;
        rd = 2'b01;
        for (int i = 0; i < 6; i++) begin
            joy0[0] = i[0];
            tick();
            chk("strobe_live", {7'b0, obs0[0]}, {7'b0, joy0[0]});
        end
        rd = 2'b00;
        joy0 = 8'h3C; tick();
        strobe_we = 1'b1; strobe = 1'b0; tick();
        strobe_we = 1'b0;
        rd = 2'b01;
        tick(); chk("reload_b0", {7'b0, obs0[0]}, 8'h00);
        tick(); chk("reload_b1", {7'b0, obs0[0]}, 8'h00);
        tick(); chk("reload_b2", {7'b0, obs0[0]}, 8'h01);
        rd = 2'b00;

        // Route zapper to port 2 mid-frame
        zap_sel = 2'b10; zap_light = 1'b0; zap_trigger = 1'b0;
        tick(); tick(); tick();
        chk("pend_no_change", {6'b0, obs_act}, 8'h00);
        vblank_start = 1'b1; tick();
        chk("vb_cycle_still_00", {6'b0, obs_act}, 8'h00);
        vblank_start = 1'b0; tick();
        chk("applied_10", {6'b0, obs_act}, 8'h02);
        chk("settle1_d43", {6'b0, obs1[4:3]}, 8'h01);
        chk("zap_port_d0", {7'b0, obs1[0]}, 8'h00);
        vblank_start = 1'b1; tick();
        vblank_start = 1'b0; tick();
        chk("settle2_d43", {6'b0, obs1[4:3]}, 8'h01);
        vblank_start = 1'b1; tick();
        vblank_start = 1'b0; tick();
        chk("tracking_d43", {6'b0, obs1[4:3]}, 8'h00);

        // Trigger pulse reported once
        zap_trigger = 1'b1; tick();
        zap_trigger = 1'b0; tick();
        rd = 2'b10;
        tick(); chk("trig_read1", {7'b0, obs1[4]}, 8'h01);
        tick(); chk("trig_read2", {7'b0, obs1[4]}, 8'h00);
        rd = 2'b00;

        // Route to port 1, then back to none
        zap_sel = 2'b01; tick();
        vblank_start = 1'b1; tick(); vblank_start = 1'b0; tick();
        for (int i = 0; i < 2; i++) begin
            vblank_start = 1'b1; tick(); vblank_start = 1'b0; tick();
        end
        chk("r01_act", {6'b0, obs_act}, 8'h01);
        chk("r01_d3_p1", {7'b0, obs0[3]}, 8'h00);
        chk("r01_d3_p2", {7'b0, obs1[3]}, 8'h00);
        zap_sel = 2'b00; tick();
        vblank_start = 1'b1; tick(); vblank_start = 1'b0; tick();
        chk("r00_act", {6'b0, obs_act}, 8'h00);
        chk("r00_d3_p1", {7'b0, obs0[3]}, 8'h00);
        chk("r00_d3_p2", {7'b0, obs1[3]}, 8'h00);
        joy0 = 8'h01;
        strobe_we = 1'b1; strobe = 1'b1; tick();
        strobe = 1'b0; tick();
        strobe_we = 1'b0;
        rd = 2'b01;
        tick(); chk("resume_b0", {7'b0, obs0[0]}, 8'h01);
        tick(); chk("resume_b1", {7'b0, obs0[0]}, 8'h00);
        rd = 2'b00;

        // Reset during settle
        zap_sel = 2'b01; tick();
        vblank_start = 1'b1; tick(); vblank_start = 1'b0; tick();
        reset = 1'b1; tick();
        reset = 1'b0; tick();
        chk("rst_settle_act", {6'b0, obs_act}, 8'h00);
        chk("rst_settle_d0", {3'b0, obs0}, 8'h01);
        chk("rst_settle_d1", {3'b0, obs1}, 8'h01);
        vblank_start = 1'b1; tick(); vblank_start = 1'b0; tick();
        chk("rst_reapply", {6'b0, obs_act}, 8'h01);
        chk("rst_settle_a", {6'b0, obs0[4:3]}, 8'h01);
        vblank_start = 1'b1; tick(); vblank_start = 1'b0; tick();
        chk("rst_settle_b", {6'b0, obs0[4:3]}, 8'h01);
        vblank_start = 1'b1; tick(); vblank_start = 1'b0; tick();
        chk("rst_settle_done", {6'b0, obs0[4:3]}, 8'h00);

        // Randomised traffic against the model
        for (int n = 0; n < 4000; n++) begin
            ce = ($urandom_range(0, 3) != 0);
            strobe_we = ($urandom_range(0, 15) == 0);
            strobe = ($urandom_range(0, 3) == 0);
            rd = 2'($urandom_range(0, 3));
            vblank_start = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 39) == 0) zap_sel = 2'($urandom_range(0, 3));
            zap_light = 1'($urandom_range(0, 1));
            zap_trigger = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 9) == 0) joy0 = 8'($urandom);
            if ($urandom_range(0, 9) == 0) joy1 = 8'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zapper_port_ctrl.md
# zapper_port_ctrl

Controller-port scheduler that shares the NES $4016/$4017 read path between the two standard pads and the light-gun (zapper) model. It serialises pad buttons through per-port shift registers and routes the zapper's light/trigger lines onto D3/D4 of the selected port. Routing changes are applied only at vblank and followed by a settle window, so a game never sees a half-switched port. It sits between the CPU I/O decode and the zapper/pad input sources.

## Interface
Parameters:
- SETTLE_FRAMES, 2, number of vblank pulses during which a newly routed zapper reports "no light, no trigger"; legal range 0-15

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  CPU clock enable; strobe_we and rd are honoured only when ce=1
- strobe  in  1  value of CPU data bit D0 on a $4016 write
- strobe_we  in  1  $4016 write pulse
- rd  in  2  rd[0] = $4016 read pulse, rd[1] = $4017 read pulse
- joy0  in  8  port-1 pad buttons, active high, bit0=A … bit7=Right
- joy1  in  8  port-2 pad buttons, same order
- zap_sel  in  2  requested routing: 00 none, 01 port 1, 10 port 2, 11 treated as 00
- zap_light  in  1  zapper light sense, active low (0 = light seen)
- zap_trigger  in  1  zapper trigger, active high
- vblank_start  in  1  one-clk pulse at start of vblank
- dout0  out  5  port-1 read data D4..D0, combinational from registered state
- dout1  out  5  port-2 read data D4..D0
- zap_active  out  2  routing currently applied (00/01/10)

## Operation
- strobe_reg: on ce & strobe_we, strobe_reg <= strobe.
- Shift registers sr0/sr1 (8 bit): each ce cycle with strobe_reg=1 (old or newly written value) reload from joy0/joy1. With strobe_reg=0, ce & rd[n] shifts sr_n right, shifting in 1; after 8 reads D0 reads 1 indefinitely.
- D0 of port n: strobe_reg ? joy_n[0] : sr_n[0]; forced 0 when port n is the applied zapper port.
- D1, D2 always 0.
- D3/D4 on the applied zapper port: D3 = zap_light, D4 = zap_trigger | trig_latch. On other ports D3=D4=0.
- trig_latch: set on any clk with zap_trigger=1. Cleared on a ce & rd read of the zapper port when zap_trigger=0 in that cycle. The cleared value is visible from the next clk, so the pulse is reported once. Held at 0 while routing is 00.
- Routing FSM:
  - IDLE: if zap_sel (11→00) differs from zap_active, go to PENDING.
  - PENDING: on vblank_start, zap_active <= requested value and settle_cnt <= SETTLE_FRAMES. Go to SETTLE, or directly to IDLE if SETTLE_FRAMES=0 or the new value is 00. If zap_sel returns to zap_active before vblank, go back to IDLE with no change.
  - SETTLE: the zapper port drives D3=1 and D4=0, and trig_latch is held 0. Each vblank_start decrements settle_cnt; at 0, go to IDLE. A zap_sel change during SETTLE is not applied until the FSM is back in IDLE (re-evaluated the next clk).

## Timing
- Reset values: strobe_reg=0, sr0=sr1=8'hFF, trig_latch=0, zap_active=00, FSM=IDLE, settle_cnt=0. Hence dout0=dout1=5'b00001.
- Shift/reload latency: 1 clk. The read-cycle dout is the value before the shift, so the CPU samples the pre-shift bit.
- Simultaneous ce & strobe_we & rd: the new strobe value governs. If it is 1, reload and no shift; if it is 0, the shift applies to the current sr.
- Simultaneous rd[0] & rd[1]: both ports shift independently.
- zap_active changes exactly 1 clk after the qualifying vblank_start.
- Reset mid-SETTLE or mid-PENDING returns to IDLE with routing 00. The pending request is re-evaluated in the first post-reset clk.

## Test plan
- Reset, then joy0=8'hA5, write strobe 1 then 0, do 10 rd[0] reads → D0 sequence 1,0,1,0,0,1,0,1,1,1.
- strobe held 1, toggle joy0[0], issue reads → D0 follows joy0[0] live and sr0 never shifts.
- zap_sel=10 mid-frame → zap_active stays 00 until vblank_start, becomes 10 one clk later. dout1 D4:D3 = 01 for 2 vblanks, then tracks the zapper; D0 of port 2 = 0.
- After settle, 1-clk zap_trigger pulse with no read, then two rd[1] reads with trigger low → D4 = 1 on the first read, 0 on the second.
- zap_light=0 with routing 01 → dout0[3]=0 and dout1[3]=0; change to routing 00 → both D3=0 and port-1 D0 resumes the pad stream.
- Assert reset during SETTLE with zap_sel=01 held → zap_active=00 and outputs 00001. Next vblank applies 01 and settle restarts from 2.
